// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the game control unit: state encodings, LED source
// codes and small state-classification helpers used by the FSM and datapath.
package unidade_controle_pkg;

  // State encodings are fixed: db_estado exposes them directly.
  typedef enum logic [3:0] {
    Inicial     = 4'h0,
    Prepara     = 4'h1,
    Mostra      = 4'h2,
    ChecaMostra = 4'h3,
    IncrEnd     = 4'h4,
    ZeraEnd     = 4'h5,
    Espera      = 4'h6,
    Registra    = 4'h7,
    Compara     = 4'h8,
    ProxJogada  = 4'h9,
    Coringa     = 4'hA,
    FimRodada   = 4'hB,
    ProxRodada  = 4'hC,
    Acertou     = 4'hD,
    Errou       = 4'hE,
    Esgotado    = 4'hF
  } estado_e;

  // LED source selection.
  localparam logic [1:0] LedBotoes  = 2'b00;
  localparam logic [1:0] LedMemoria = 2'b01;
  localparam logic [1:0] LedApagado = 2'b10;

  localparam int unsigned CoringasW = 3;

  // Datapath control strobes produced by the FSM.
  typedef struct packed {
    logic zera_l;
    logic conta_l;
    logic zera_e;
    logic conta_e;
    logic limpa_r;
    logic registra_r;
    logic limpa_m;
    logic registra_m;
    logic zera_tmr;
    logic conta_tmr;
    logic reset_timer;
  } controle_t;

  // Game-status flags.
  typedef struct packed {
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic timeout;
  } status_t;

  // States in which the start request is sampled.
  function automatic logic aceita_iniciar(estado_e e);
    return (e == Inicial) || (e == Acertou) || (e == Errou) || (e == Esgotado);
  endfunction

  // Terminal states of a game.
  function automatic logic estado_final(estado_e e);
    return (e == Acertou) || (e == Errou) || (e == Esgotado);
  endfunction

endpackage

// File: rtl/unidade_controle.sv
// Memory-game control unit: Moore FSM sequencing display, play, wildcard and
// round bookkeeping, plus an inline wildcard-use counter.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int unsigned CORINGAS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic                 fimTMR,
  input  logic                 enderecoIgualLimite,
  input  logic                 chavesIgualMemoria,
  input  logic                 jogada_feita,
  input  logic                 botao_coringa_out,
  input  logic                 timeout,
  input  logic                 fimL,
  output logic                 zeraL,
  output logic                 contaL,
  output logic                 zeraE,
  output logic                 contaE,
  output logic                 limpaR,
  output logic                 registraR,
  output logic                 limpaM,
  output logic                 registraM,
  output logic                 zeraTMR,
  output logic                 contaTMR,
  output logic                 reset_timer,
  output logic [1:0]           BotoesOuMemoria,
  output logic                 pronto,
  output logic                 ganhou,
  output logic                 perdeu,
  output logic                 db_timeout,
  output logic [CoringasW-1:0] db_coringas,
  output logic [3:0]           db_estado
);

  localparam logic [CoringasW-1:0] CoringasIni = CoringasW'(CORINGAS);

  estado_e                estado_q, estado_d;
  logic [CoringasW-1:0]   coringas_q, coringas_d;
  logic                   tem_coringa;
  controle_t              ctrl;
  status_t                stat;
  logic [1:0]             led_sel;

  assign tem_coringa = (coringas_q != '0);

  // State register; reset abandons any game in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= Inicial;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Wildcard counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      coringas_q <= CoringasIni;
    end else begin
      coringas_q <= coringas_d;
    end
  end

  // Wildcard counter: reloaded per game, spent one per CORINGA visit, never wraps.
  always_comb begin
    coringas_d = coringas_q;
    if (estado_q == Prepara) begin
      coringas_d = CoringasIni;
    end else if ((estado_q == Coringa) && tem_coringa) begin
      coringas_d = coringas_q - 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      Inicial, Acertou, Errou, Esgotado: begin
        if (iniciar) estado_d = Prepara;
      end
      Prepara:     estado_d = Mostra;
      Mostra: begin
        if (fimTMR) estado_d = ChecaMostra;
      end
      ChecaMostra: estado_d = enderecoIgualLimite ? ZeraEnd : IncrEnd;
      IncrEnd:     estado_d = Mostra;
      ZeraEnd:     estado_d = Espera;
      Espera: begin
        // Timeout beats a play; a play beats a wildcard press on the same cycle.
        if (timeout) begin
          estado_d = Esgotado;
        end else if (jogada_feita) begin
          estado_d = Registra;
        end else if (botao_coringa_out && tem_coringa) begin
          estado_d = Coringa;
        end
      end
      Registra:    estado_d = Compara;
      Compara: begin
        if (!chavesIgualMemoria) begin
          estado_d = Errou;
        end else if (enderecoIgualLimite) begin
          estado_d = FimRodada;
        end else begin
          estado_d = ProxJogada;
        end
      end
      ProxJogada:  estado_d = Espera;
      // A wildcard counts as a correct play.
      Coringa:     estado_d = enderecoIgualLimite ? FimRodada : ProxJogada;
      FimRodada:   estado_d = fimL ? Acertou : ProxRodada;
      ProxRodada:  estado_d = Mostra;
      default:     estado_d = Inicial;
    endcase
  end

  // Moore output decode. INICIAL keeps everything low so reset drives all
  // outputs to zero; ESPERA is the only other state that releases reset_timer.
  always_comb begin
    ctrl             = '0;
    stat             = '0;
    led_sel          = LedApagado;
    ctrl.reset_timer = 1'b1;
    case (estado_q)
      Inicial: begin
        ctrl.reset_timer = 1'b0;
        led_sel          = LedBotoes;
      end
      Prepara: begin
        ctrl.zera_l   = 1'b1;
        ctrl.zera_e   = 1'b1;
        ctrl.limpa_r  = 1'b1;
        ctrl.limpa_m  = 1'b1;
        ctrl.zera_tmr = 1'b1;
      end
      Mostra: begin
        led_sel        = LedMemoria;
        ctrl.conta_tmr = 1'b1;
      end
      ChecaMostra: begin
        ctrl.zera_tmr   = 1'b1;
        ctrl.registra_m = 1'b1;
      end
      IncrEnd:    ctrl.conta_e = 1'b1;
      ZeraEnd:    ctrl.zera_e  = 1'b1;
      Espera: begin
        led_sel          = LedBotoes;
        ctrl.reset_timer = 1'b0;
      end
      Registra:   ctrl.registra_r = 1'b1;
      ProxJogada: ctrl.conta_e    = 1'b1;
      ProxRodada: begin
        ctrl.conta_l  = 1'b1;
        ctrl.zera_e   = 1'b1;
        ctrl.zera_tmr = 1'b1;
      end
      Acertou: begin
        stat.ganhou = 1'b1;
        stat.pronto = 1'b1;
      end
      Errou: begin
        stat.perdeu = 1'b1;
        stat.pronto = 1'b1;
      end
      Esgotado: begin
        stat.perdeu  = 1'b1;
        stat.timeout = 1'b1;
        stat.pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  assign zeraL           = ctrl.zera_l;
  assign contaL          = ctrl.conta_l;
  assign zeraE           = ctrl.zera_e;
  assign contaE          = ctrl.conta_e;
  assign limpaR          = ctrl.limpa_r;
  assign registraR       = ctrl.registra_r;
  assign limpaM          = ctrl.limpa_m;
  assign registraM       = ctrl.registra_m;
  assign zeraTMR         = ctrl.zera_tmr;
  assign contaTMR        = ctrl.conta_tmr;
  assign reset_timer     = ctrl.reset_timer;
  assign BotoesOuMemoria = led_sel;
  assign pronto          = stat.pronto;
  assign ganhou          = stat.ganhou;
  assign perdeu          = stat.perdeu;
  assign db_timeout      = stat.timeout;
  assign db_coringas     = coringas_q;
  assign db_estado       = estado_q;

endmodule
